// File: rtl/iommu_pkg.sv
// Shared IOMMU definitions: reg-to-AXI-Lite bridge FSM states and AXI response codes.
package iommu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WRESP,
        ST_READ,
        ST_RRESP,
        ST_DONE
    } reg2axil_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic resp_is_error(input logic [1:0] resp);
        return !((resp == RESP_OKAY) || (resp == RESP_EXOKAY));
    endfunction

endpackage

// File: rtl/iommu_reg_to_axi_lite.sv
// Single-outstanding bridge from a valid/ready register request port to an AXI-Lite master.
// All AXI valids/readies are decoded from registered state only.
module iommu_reg_to_axi_lite
    import iommu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter logic [2:0]  AXI_PROT   = 3'b000,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  reg_valid_i,
    output logic                  reg_ready_o,
    input  logic [ADDR_WIDTH-1:0] reg_addr_i,
    input  logic                  reg_write_i,
    input  logic [DATA_WIDTH-1:0] reg_wdata_i,
    input  logic [STRB_WIDTH-1:0] reg_wstrb_i,
    output logic [DATA_WIDTH-1:0] reg_rdata_o,
    output logic                  reg_error_o,

    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic [2:0]            m_awprot,

    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [STRB_WIDTH-1:0] m_wstrb,

    input  logic                  m_bvalid,
    output logic                  m_bready,
    input  logic [1:0]            m_bresp,

    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [2:0]            m_arprot,

    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp
);

    reg2axil_state_e       state_q, state_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  error_q, error_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        error_d   = error_q;

        case (state_q)
            ST_IDLE: begin
                if (reg_valid_i) begin
                    addr_d    = reg_addr_i;
                    wdata_d   = reg_wdata_i;
                    wstrb_d   = reg_wstrb_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = reg_write_i ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                // AW and W complete independently, possibly in the same cycle
                if (m_awvalid && m_awready) aw_done_d = 1'b1;
                if (m_wvalid && m_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)  state_d   = ST_WRESP;
            end
            ST_WRESP: begin
                if (m_bvalid) begin
                    error_d = resp_is_error(m_bresp);
                    rdata_d = '0;
                    state_d = ST_DONE;
                end
            end
            ST_READ: begin
                if (m_arready) state_d = ST_RRESP;
            end
            ST_RRESP: begin
                if (m_rvalid) begin
                    error_d = resp_is_error(m_rresp);
                    rdata_d = m_rdata;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign m_awvalid   = (state_q == ST_WRITE) && !aw_done_q;
    assign m_wvalid    = (state_q == ST_WRITE) && !w_done_q;
    assign m_bready    = (state_q == ST_WRESP);
    assign m_arvalid   = (state_q == ST_READ);
    assign m_rready    = (state_q == ST_RRESP);
    assign reg_ready_o = (state_q == ST_DONE);

    assign m_awaddr    = addr_q;
    assign m_araddr    = addr_q;
    assign m_awprot    = AXI_PROT;
    assign m_arprot    = AXI_PROT;
    assign m_wdata     = wdata_q;
    assign m_wstrb     = wstrb_q;
    assign reg_rdata_o = rdata_q;
    assign reg_error_o = error_q;

endmodule
